// File: rtl/pr_defs_pkg.sv
// Shared pipeline-register definitions: elastic-stage state encodings and the
// packed field layout of the EX/MEM payload.
package pr_defs;

    typedef enum logic [1:0] {
        PR_EMPTY = 2'd0,
        PR_ONE   = 2'd1,
        PR_FULL  = 2'd2
    } pr_state_e;

    // EX/MEM payload fields, packed MSB-first as {pc, alu_result, rd, ctrl}.
    localparam int EXMEM_PC_W    = 32;
    localparam int EXMEM_ALU_W   = 32;
    localparam int EXMEM_RD_W    = 5;
    localparam int EXMEM_CTRL_W  = 8;
    localparam int EXMEM_TOTAL_W = EXMEM_PC_W + EXMEM_ALU_W + EXMEM_RD_W + EXMEM_CTRL_W;

    function automatic logic [1:0] pr_occupancy(input pr_state_e st);
        case (st)
            PR_EMPTY: pr_occupancy = 2'd0;
            PR_ONE:   pr_occupancy = 2'd1;
            PR_FULL:  pr_occupancy = 2'd2;
            default:  pr_occupancy = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pr_data_slot.sv
// One payload register with load and clear-to-RESET_DATA; reset and clear
// take priority over load.
module pr_data_slot #(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (clear) begin
            data_d = RESET_DATA;
        end else if (load) begin
            data_d = d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            data_q <= RESET_DATA;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pr_elastic.sv
// Two-entry elastic pipeline register (main + skid slot) with flush and
// optional zeroing of the payload whenever no valid entry is presented.
module pr_elastic
    import pr_defs::*;
#(
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] RESET_DATA  = '0,
    parameter bit                ZERO_BUBBLE = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [1:0]        OCCUPANCY,
    output logic [1:0]        DBG_STATE
);

    // Handshake: a transfer happens on a posedge where valid and ready are both
    // high; valid never waits on ready, and IN_READY comes straight from a flop
    // so no combinational path exists from OUT_READY to IN_READY.
    pr_state_e state_d, state_q;
    logic      in_ready_d, in_ready_q;

    logic              in_fire;
    logic              out_fire;
    logic              main_load, main_clear, main_from_skid;
    logic              skid_load, skid_clear;
    logic [DATA_W-1:0] main_in;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;

    assign in_fire  = IN_VALID & in_ready_q;
    assign out_fire = OUT_VALID & OUT_READY;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;

        case (state_q)
            PR_EMPTY: begin
                if (in_fire) begin
                    main_load = 1'b1;
                    state_d   = PR_ONE;
                end
            end
            PR_ONE: begin
                if (in_fire && !out_fire) begin
                    skid_load = 1'b1;
                    state_d   = PR_FULL;
                end else if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end else if (out_fire) begin
                    main_clear = ZERO_BUBBLE;
                    skid_clear = ZERO_BUBBLE;
                    state_d    = PR_EMPTY;
                end
            end
            PR_FULL: begin
                if (out_fire) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clear     = ZERO_BUBBLE;
                    state_d        = PR_ONE;
                end
            end
            default: begin
                state_d = PR_EMPTY;
            end
        endcase

        // Squash wins over any handshake in the same cycle.
        if (FLUSH) begin
            state_d    = PR_EMPTY;
            main_load  = 1'b0;
            skid_load  = 1'b0;
            main_clear = ZERO_BUBBLE;
            skid_clear = ZERO_BUBBLE;
        end

        in_ready_d = (state_d != PR_FULL);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= PR_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign main_in = main_from_skid ? skid_q : IN_DATA;

    pr_data_slot #(
        .DATA_W     (DATA_W),
        .RESET_DATA (RESET_DATA)
    ) u_main (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .load    (main_load),
        .clear   (main_clear),
        .d       (main_in),
        .q       (main_q)
    );

    pr_data_slot #(
        .DATA_W     (DATA_W),
        .RESET_DATA (RESET_DATA)
    ) u_skid (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .load    (skid_load),
        .clear   (skid_clear),
        .d       (IN_DATA),
        .q       (skid_q)
    );

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = (state_q != PR_EMPTY);
    assign OUT_DATA  = main_q;
    assign OCCUPANCY = pr_occupancy(state_q);
    assign DBG_STATE = state_q;

endmodule
